// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               byte-stream instruction-memory loader.
// Config      : LOADER_CHECKSUM_EN adds the CSUM state (trailing XOR byte).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int c_hdr_width  = 16;  // word-count header, little-endian
  localparam int c_byte_width = 8;   // stream payload width

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`endif

  // States in which the loader consumes stream bytes.
  function automatic logic state_ready(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_LEN0, S_LEN1, S_DATA: r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                 r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs accepted data bytes little-endian into instruction
//               words, counts bytes/words and issues a one-cycle IMEM write.
// Ports       : clk, rst_n        - clock, async active-low reset
//               byte_valid_i      - a data byte is accepted this cycle
//               byte_i            - the accepted byte
//               word_count_i      - number of words in the image (N)
//               last_byte_o       - this accepted byte completes word N-1
//               imem_we_o/addr_o/wdata_o - registered IMEM write port
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    byte_valid_i,
  input  logic [c_byte_width-1:0] byte_i,
  input  logic [ADDR_WIDTH:0]     word_count_i,
  output logic                    last_byte_o,
  output logic                    imem_we_o,
  output logic [ADDR_WIDTH-1:0]   imem_addr_o,
  output logic [DATA_WIDTH-1:0]   imem_wdata_o
);

  localparam int c_bytes_per_word = DATA_WIDTH / c_byte_width;
  localparam int c_cnt_width      = $clog2(c_bytes_per_word);
  localparam int c_acc_width      = DATA_WIDTH - c_byte_width;

  logic [c_cnt_width-1:0] byte_cnt_q;
  logic [c_acc_width-1:0] acc_q;       // lower bytes of the word in flight
  logic [ADDR_WIDTH:0]    word_idx_q;  // one extra bit so N = 2^ADDR_WIDTH does not wrap
  logic                   imem_we_q;
  logic [ADDR_WIDTH-1:0]  imem_addr_q;
  logic [DATA_WIDTH-1:0]  imem_wdata_q;

  logic                   w_word_end;
  logic [ADDR_WIDTH:0]    w_idx_next;

  assign w_word_end  = byte_valid_i && (byte_cnt_q == c_cnt_width'(c_bytes_per_word - 1));
  assign w_idx_next  = word_idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_byte_o = w_word_end && (w_idx_next == word_count_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q   <= '0;
      acc_q        <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (byte_valid_i) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        if (w_word_end) begin
          // Top byte goes straight into the output word; no need to store it.
          imem_wdata_q <= {byte_i, acc_q};
          imem_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
          word_idx_q   <= w_idx_next;
          imem_we_q    <= 1'b1;
        end else begin
          acc_q[{byte_cnt_q, 3'b000} +: c_byte_width] <= byte_i;
        end
      end
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader that receives a length-prefixed byte stream,
//               writes it into IMEM word by word and then releases the CPU.
//               Stream: N[7:0], N[15:8], N*4 data bytes (LE words)
//               [, XOR checksum byte when LOADER_CHECKSUM_EN is defined].
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid/in_data/in_ready - byte stream handshake
//               imem_we/addr/wdata    - IMEM write port
//               cpu_rst, done, error  - CPU hold and load status
// Config      : LOADER_CHECKSUM_EN    - enables trailing checksum check
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [c_byte_width-1:0] in_data,
  output logic                    in_ready,
  output logic                    imem_we,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_wdata,
  output logic                    cpu_rst,
  output logic                    done,
  output logic                    error
);

  state_t                  state_q, state_d;
  logic [c_byte_width-1:0] len_lo_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic                    in_ready_q;
  logic                    cpu_rst_q;
  logic                    done_q;
  logic                    error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [c_byte_width-1:0] xor_q;
`endif

  logic                    w_accept;
  logic                    w_data_byte;
  logic                    w_last;
  logic [c_hdr_width-1:0]  w_len;
  logic                    w_len_too_big;

  assign w_accept      = in_valid && in_ready_q;
  assign w_data_byte   = w_accept && (state_q == S_DATA);
  assign w_len         = {in_data, len_lo_q};
  assign w_len_too_big = (32'(w_len) > (32'd1 << ADDR_WIDTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: if (w_accept) state_d = S_LEN1;
      S_LEN1: begin
        if (w_accept) begin
          if (w_len_too_big)     state_d = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
          else if (w_len == '0)  state_d = S_CSUM;
`else
          else if (w_len == '0)  state_d = S_FLUSH;
`endif
          else                   state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_DATA: if (w_last) state_d = S_CSUM;
      S_CSUM: if (w_accept) state_d = (in_data == xor_q) ? S_FLUSH : S_ERROR;
`else
      S_DATA: if (w_last) state_d = S_FLUSH;
`endif
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LEN0;
      len_lo_q   <= '0;
      len_q      <= '0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (w_accept && (state_q == S_LEN0)) len_lo_q <= in_data;
      if (w_accept && (state_q == S_LEN1)) len_q    <= w_len[ADDR_WIDTH:0];
`ifdef LOADER_CHECKSUM_EN
      if (w_data_byte) xor_q <= xor_q ^ in_data;
`endif
      in_ready_q <= state_ready(state_d);
      cpu_rst_q  <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
    end
  end

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_word_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (w_data_byte),
    .byte_i       (in_data),
    .word_count_i (len_q),
    .last_byte_o  (w_last),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata)
  );

  assign in_ready = in_ready_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected IMEM writes are
//               queued as bytes are driven and popped when imem_we fires.
// Config      : LOADER_CHECKSUM_EN adds checksum trailer and checksum tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int DW = 32;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, cpu_rst, done, error;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  logic [31:0]      img[$];

  always #5 clk = ~clk;

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr=%0h wdata=%h, required no write", imem_addr, imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp_w)
          $display("FAIL write: addr=%0h wdata=%h, required addr=%0h wdata=%h",
                   imem_addr, imem_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        else n_pass++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until accepted; rnd toggles in_valid randomly and puts
  // junk on in_data whenever in_valid is low.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? b : 8'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL byte_timeout: byte %h not accepted, in_ready=%b required 1", b, in_ready);
    end
  endtask

  // Header, img words (expected writes queued) and optional checksum trailer.
  task automatic send_image(input logic [15:0] n, input bit bad, input bit rnd);
    logic [7:0] cs;
    cs = {7'b0, bad};
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({i[AW-1:0], img[i]});
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ img[i][8*k +: 8];
        send_byte(img[i][8*k +: 8], rnd);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs, rnd);
`endif
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b0)  $display("FAIL reset_in_ready: %b required 0", in_ready); else n_pass++;
    n_total++; if (imem_we !== 1'b0)   $display("FAIL reset_imem_we: %b required 0", imem_we); else n_pass++;
    n_total++; if (imem_addr !== '0 || imem_wdata !== '0)
      $display("FAIL reset_imem_bus: addr=%0h wdata=%h required 0", imem_addr, imem_wdata); else n_pass++;
    n_total++; if (cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_status: cpu_rst=%b done=%b error=%b required 1 0 0", cpu_rst, done, error); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: %b required 1", in_ready); else n_pass++;
  endtask

  task automatic test_two_words();
    do_reset();
    img = '{32'h00100513, 32'h00200593};
    send_image(16'd2, 1'b0, 1'b0);
    @(negedge clk);
`ifndef LOADER_CHECKSUM_EN
    n_total++; if (imem_we !== 1'b1) $display("FAIL two_words_we_t1: %b required 1", imem_we); else n_pass++;
`endif
    n_total++; if (done !== 1'b0) $display("FAIL two_words_done_t1: %b required 0", done); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL two_words_done_t2: done=%b cpu_rst=%b in_ready=%b required 1 0 0", done, cpu_rst, in_ready); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (exp_q.size() != 0) $display("FAIL two_words_pending: %0d writes missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_empty();
    do_reset();
    img.delete();
    send_image(16'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL empty_done_t1: %b required 0", done); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0)
      $display("FAIL empty_done_t2: done=%b cpu_rst=%b error=%b required 1 0 0", done, cpu_rst, error); else n_pass++;
  endtask

  task automatic test_oversize();
    do_reset();
    img.delete();
    send_image(16'h0801, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (error !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL oversize_error: error=%b cpu_rst=%b in_ready=%b done=%b required 1 1 0 0",
               error, cpu_rst, in_ready, done); else n_pass++;
    // Bytes offered in ERROR must be ignored and leave the state terminal.
    in_valid = 1'b1;
    in_data  = 8'h13;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (error !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL oversize_terminal: error=%b in_ready=%b required 1 0", error, in_ready); else n_pass++;
  endtask

  task automatic test_max_len();
    do_reset();
    img.delete();
    for (int i = 0; i < 2048; i++) img.push_back(32'h1234_0000 ^ (i * 32'h9E37_79B9));
    send_image(16'h0800, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_total++; if (done !== 1'b1 || error !== 1'b0)
      $display("FAIL max_len_done: done=%b error=%b required 1 0", done, error); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL max_len_pending: %0d writes missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_random_valid();
    do_reset();
    img = '{32'hDEAD_BEEF};
    send_image(16'd1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL random_valid_done: %b required 1", done); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL random_valid_pending: %0d writes missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL midload_async_reset: in_ready=%b cpu_rst=%b required 0 1", in_ready, cpu_rst); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    img = '{32'h0000_0093};
    send_image(16'd1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL midload_done: %b required 1", done); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL midload_pending: %0d writes missing, required 0", exp_q.size()); else n_pass++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    img = '{32'hCAFE_F00D, 32'h0102_0408};
    send_image(16'd2, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_total++; if (done !== 1'b1 || error !== 1'b0)
      $display("FAIL csum_good: done=%b error=%b required 1 0", done, error); else n_pass++;
    do_reset();
    img = '{32'hCAFE_F00D, 32'h0102_0408};
    send_image(16'd2, 1'b1, 1'b0);
    @(negedge clk);
    n_total++; if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0)
      $display("FAIL csum_bad: error=%b cpu_rst=%b done=%b required 1 1 0", error, cpu_rst, done); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (exp_q.size() != 0) $display("FAIL csum_pending: %0d writes missing, required 0", exp_q.size()); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_empty();
    test_oversize();
    test_random_valid();
    test_reset_midload();
    test_max_len();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
